// File: rtl/id_stage.sv
// RV32I decode stage: register file, instruction/immediate decode, load-use stall, ID/EX register.
// Define WB_BYPASS_EN to make a same-cycle write-back visible on the register read ports.
module id_stage #(
    parameter int          XLEN     = 32,
    parameter int          NREG     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] pc_orig_id,
    input  logic [31:0]     inst_id,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic [5:0]      ex_ctrl,
    output logic [2:0]      ex_funct3,
    output logic            ex_illegal
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB  = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR  = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR = 4'd8,   ALU_AND  = 4'd9, ALU_PASSB = 4'd10;

    logic [XLEN-1:0] regs [0:NREG-1];
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1, rs2, rd_f;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] dec_imm;
    logic [3:0]      dec_op;
    logic            dec_src, dec_writes, dec_illegal, use_rs1, use_rs2;
    logic            is_jal, is_jalr, is_branch, is_load, is_store;
    logic [5:0]      dec_ctrl;
    logic [4:0]      dec_rd;
    logic            load_id;

    assign opc  = inst_id[6:0];
    assign f3   = inst_id[14:12];
    assign f7   = inst_id[31:25];
    assign rd_f = inst_id[11:7];
    assign rs1  = inst_id[19:15];
    assign rs2  = inst_id[24:20];

    assign imm_i = {{20{inst_id[31]}}, inst_id[31:20]};
    assign imm_s = {{20{inst_id[31]}}, inst_id[31:25], inst_id[11:7]};
    assign imm_b = {{20{inst_id[31]}}, inst_id[7], inst_id[30:25], inst_id[11:8], 1'b0};
    assign imm_u = {inst_id[31:12], 12'h000};
    assign imm_j = {{12{inst_id[31]}}, inst_id[19:12], inst_id[20], inst_id[30:21], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = (rs1 == 5'd0) ? '0 : regs[rs1];
        rs2_data = (rs2 == 5'd0) ? '0 : regs[rs2];
`ifdef WB_BYPASS_EN
        if (wb_en && wb_rd != 5'd0 && wb_rd == rs1) rs1_data = wb_data;
        if (wb_en && wb_rd != 5'd0 && wb_rd == rs2) rs2_data = wb_data;
`endif
    end

    function automatic logic [3:0] alu_fn(input logic [2:0] fn3, input logic alt);
        case (fn3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec_imm     = '0;
        dec_op      = ALU_ADD;
        dec_src     = 1'b0;
        dec_writes  = 1'b0;
        dec_illegal = 1'b0;
        use_rs1     = 1'b1;
        use_rs2     = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        is_branch   = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        case (opc)
            OPC_LUI:    begin dec_imm = imm_u; dec_op = ALU_PASSB; dec_src = 1'b1; dec_writes = 1'b1; use_rs1 = 1'b0; end
            OPC_AUIPC:  begin dec_imm = imm_u; dec_src = 1'b1; dec_writes = 1'b1; use_rs1 = 1'b0; end
            OPC_JAL:    begin dec_imm = imm_j; dec_src = 1'b1; dec_writes = 1'b1; use_rs1 = 1'b0; is_jal = 1'b1; end
            OPC_JALR:   begin
                dec_imm = imm_i; dec_src = 1'b1; dec_writes = 1'b1; is_jalr = 1'b1;
                dec_illegal = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                dec_imm = imm_b; dec_op = ALU_SUB; use_rs2 = 1'b1; is_branch = 1'b1;
                dec_illegal = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_LOAD:   begin
                dec_imm = imm_i; dec_src = 1'b1; dec_writes = 1'b1; is_load = 1'b1;
                dec_illegal = (f3 == 3'd3) || (f3 >= 3'd6);
            end
            OPC_STORE:  begin
                dec_imm = imm_s; dec_src = 1'b1; use_rs2 = 1'b1; is_store = 1'b1;
                dec_illegal = (f3 > 3'd2);
            end
            OPC_OPIMM:  begin
                // No SUBI: funct7 bit 5 only selects SRAI.
                dec_imm = imm_i; dec_src = 1'b1; dec_writes = 1'b1;
                dec_op = alu_fn(f3, inst_id[30] && f3 == 3'd5);
                dec_illegal = (f3 == 3'd1 && f7 != 7'h00) ||
                              (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            OPC_OP:     begin
                use_rs2 = 1'b1; dec_writes = 1'b1;
                dec_op = alu_fn(f3, inst_id[30]);
                dec_illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            default:    dec_illegal = 1'b1;
        endcase
    end

    assign dec_ctrl = dec_illegal ? 6'd0 :
                      {is_jal, is_jalr, is_branch, is_load, is_store, dec_writes && rd_f != 5'd0};
    assign dec_rd   = (dec_writes && !dec_illegal) ? rd_f : 5'd0;

    assign stall = !flush && id_valid && ex_valid && ex_ctrl[2] && ex_rd != 5'd0 &&
                   ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));

    assign load_id = id_valid && !flush && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= RESET_PC;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_alu_op   <= '0;
            ex_alu_src  <= 1'b0;
            ex_ctrl     <= '0;
            ex_funct3   <= '0;
            ex_illegal  <= 1'b0;
        end else begin
            // Bubbles only clear valid/ctrl/illegal; the data fields are don't-care then.
            ex_valid    <= load_id;
            ex_pc       <= pc_orig_id;
            ex_rs1_data <= rs1_data;
            ex_rs2_data <= rs2_data;
            ex_imm      <= dec_imm;
            ex_rd       <= dec_rd;
            ex_alu_op   <= dec_op;
            ex_alu_src  <= dec_src;
            ex_ctrl     <= load_id ? dec_ctrl : 6'd0;
            ex_funct3   <= f3;
            ex_illegal  <= load_id && dec_illegal;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus a randomized run against a spec-level model.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, flush, wb_en;
    logic [31:0] pc_orig_id, inst_id, wb_data;
    logic [4:0]  wb_rd;
    logic        stall, ex_valid, ex_alu_src, ex_illegal;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_op;
    logic [5:0]  ex_ctrl;
    logic [2:0]  ex_funct3;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [31:0] LW_X3  = 32'h0000A183;
    localparam logic [31:0] ADD_X3 = 32'h003201B3;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .pc_orig_id(pc_orig_id), .inst_id(inst_id),
        .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_ctrl(ex_ctrl), .ex_funct3(ex_funct3), .ex_illegal(ex_illegal)
    );

    typedef struct {
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        src;
        logic [5:0]  ctrl;
        logic        ill;
        logic        u1;
        logic        u2;
    } dec_t;

    // Spec-level decode: immediates built arithmetically from the bit fields.
    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        int alu_tab [8];
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic wr, jl, jr, br, ld, st;
        alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
        opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        d = '{imm: 0, rd: 0, op: 0, src: 0, ctrl: 0, ill: 0, u1: 0, u2: 0};
        {wr, jl, jr, br, ld, st} = 6'b0;
        d.u1 = !(opc inside {7'h37, 7'h17, 7'h6F});
        d.u2 = opc inside {7'h63, 7'h23, 7'h33};
        case (opc)
            7'h37: begin d.imm = i & 32'hFFFFF000; d.op = 10; d.src = 1; wr = 1; end
            7'h17: begin d.imm = i & 32'hFFFFF000; d.src = 1; wr = 1; end
            7'h6F: begin
                d.imm = 32'(int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2 - (i[31] ? (1 << 20) : 0));
                d.src = 1; wr = 1; jl = 1;
            end
            7'h67: begin d.imm = 32'(int'(i[31:20]) - (i[31] ? 4096 : 0)); d.src = 1; wr = 1; jr = 1; d.ill = (f3 != 0); end
            7'h63: begin
                d.imm = 32'(int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2 - (i[31] ? 4096 : 0));
                d.op = 1; br = 1; d.ill = (f3 == 2 || f3 == 3);
            end
            7'h03: begin d.imm = 32'(int'(i[31:20]) - (i[31] ? 4096 : 0)); d.src = 1; wr = 1; ld = 1; d.ill = !(f3 inside {0, 1, 2, 4, 5}); end
            7'h23: begin d.imm = 32'(int'({i[31:25], i[11:7]}) - (i[31] ? 4096 : 0)); d.src = 1; st = 1; d.ill = (f3 > 2); end
            7'h13: begin
                d.imm = 32'(int'(i[31:20]) - (i[31] ? 4096 : 0)); d.src = 1; wr = 1;
                d.op = (f3 == 5 && f7 == 7'h20) ? 4'd7 : 4'(alu_tab[f3]);
                d.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {7'h00, 7'h20}));
            end
            7'h33: begin
                wr = 1;
                d.op = (f7 == 7'h20) ? ((f3 == 0) ? 4'd1 : 4'd7) : 4'(alu_tab[f3]);
                d.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
            end
            default: d.ill = 1;
        endcase
        if (!d.ill) begin
            d.ctrl = {jl, jr, br, ld, st, wr && i[11:7] != 0};
            d.rd   = wr ? i[11:7] : 5'd0;
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; id_valid = 0; flush = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
        pc_orig_id = 0; inst_id = 0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        id_valid = 1; inst_id = LW_X3; pc_orig_id = 32'h40;
        tick();
        rst_n = 1'b0;
        #2;
        total_cnt++; if (ex_valid !== 1'b0) $display("FAIL rst_valid got %0h want 0", ex_valid); else pass_cnt++;
        total_cnt++; if (ex_pc !== 32'h0) $display("FAIL rst_pc got %0h want 0", ex_pc); else pass_cnt++;
        total_cnt++; if (ex_ctrl !== 6'h0) $display("FAIL rst_ctrl got %0h want 0", ex_ctrl); else pass_cnt++;
        total_cnt++; if (ex_rd !== 5'h0 || ex_imm !== 32'h0 || ex_funct3 !== 3'h0)
            $display("FAIL rst_fields got rd=%0h imm=%0h f3=%0h want 0", ex_rd, ex_imm, ex_funct3); else pass_cnt++;
        total_cnt++; if (ex_alu_src !== 1'b0 || ex_illegal !== 1'b0 || ex_alu_op !== 4'h0)
            $display("FAIL rst_misc got src=%0h ill=%0h op=%0h want 0", ex_alu_src, ex_illegal, ex_alu_op); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall got %0h want 0", stall); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        inst_id = 32'h00028093; // addi x1,x5,0
        tick();
        total_cnt++; if (ex_rs1_data !== 32'h0) $display("FAIL rst_x5 got %0h want 0", ex_rs1_data); else pass_cnt++;
        $display("reset test done");
    endtask

    task automatic test_addi();
        do_reset();
        wb_en = 1; wb_rd = 1; wb_data = 32'h10;
        tick();
        wb_en = 0; id_valid = 1; inst_id = 32'h00508113; pc_orig_id = 32'h4;
        tick();
        total_cnt++; if (ex_rs1_data !== 32'h10) $display("FAIL addi_rs1 got %0h want 10", ex_rs1_data); else pass_cnt++;
        total_cnt++; if (ex_imm !== 32'h5) $display("FAIL addi_imm got %0h want 5", ex_imm); else pass_cnt++;
        total_cnt++; if (ex_rd !== 5'd2) $display("FAIL addi_rd got %0h want 2", ex_rd); else pass_cnt++;
        total_cnt++; if (ex_alu_op !== 4'd0 || ex_alu_src !== 1'b1)
            $display("FAIL addi_alu got op=%0h src=%0h want op=0 src=1", ex_alu_op, ex_alu_src); else pass_cnt++;
        total_cnt++; if (ex_pc !== 32'h4 || ex_valid !== 1'b1 || ex_ctrl !== 6'b000001)
            $display("FAIL addi_pc got pc=%0h v=%0h ctrl=%0h want 4/1/1", ex_pc, ex_valid, ex_ctrl); else pass_cnt++;
        $display("addi test: rs1=%0h imm=%0h rd=%0d", ex_rs1_data, ex_imm, ex_rd);
    endtask

    task automatic test_load_use(input logic do_flush);
        do_reset();
        id_valid = 1; inst_id = LW_X3; pc_orig_id = 32'h8;
        tick();
        total_cnt++; if (ex_ctrl !== 6'b000101 || ex_rd !== 5'd3)
            $display("FAIL lu_load got ctrl=%0h rd=%0h want 5/3", ex_ctrl, ex_rd); else pass_cnt++;
        inst_id = ADD_X3; pc_orig_id = 32'hC; flush = do_flush;
        #1;
        total_cnt++; if (stall !== !do_flush) $display("FAIL lu_stall got %0h want %0h", stall, !do_flush); else pass_cnt++;
        tick();
        flush = 0;
        total_cnt++; if (ex_valid !== 1'b0 || ex_ctrl !== 6'h0)
            $display("FAIL lu_bubble got v=%0h ctrl=%0h want 0/0", ex_valid, ex_ctrl); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL lu_stall_once got %0h want 0", stall); else pass_cnt++;
        tick();
        total_cnt++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_pc !== 32'hC || ex_ctrl !== 6'b000001)
            $display("FAIL lu_issue got v=%0h rd=%0h pc=%0h ctrl=%0h want 1/3/c/1", ex_valid, ex_rd, ex_pc, ex_ctrl); else pass_cnt++;
        $display("load-use test flush=%0d done", do_flush);
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        id_valid = 1; inst_id = LW_X3;
        tick();
        inst_id = ADD_X3;
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (stall !== 1'b0 || ex_valid !== 1'b0)
            $display("FAIL mid_rst got stall=%0h v=%0h want 0/0", stall, ex_valid); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        $display("reset mid-stall test done");
    endtask

    task automatic test_x0_and_same_cycle();
        logic [31:0] exp_byp;
        do_reset();
        wb_en = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF;
        tick();
        wb_en = 0; id_valid = 1; inst_id = 32'h00000033;
        tick();
        total_cnt++; if (ex_rs1_data !== 32'h0 || ex_rd !== 5'd0)
            $display("FAIL x0 got rs1=%0h rd=%0h want 0/0", ex_rs1_data, ex_rd); else pass_cnt++;
`ifdef WB_BYPASS_EN
        exp_byp = 32'hA5A5;
`else
        exp_byp = 32'h0;
`endif
        wb_en = 1; wb_rd = 7; wb_data = 32'hA5A5; inst_id = 32'h00038413; // addi x8,x7,0
        tick();
        total_cnt++; if (ex_rs1_data !== exp_byp) $display("FAIL same_cycle got %0h want %0h", ex_rs1_data, exp_byp); else pass_cnt++;
        wb_en = 0;
        tick();
        total_cnt++; if (ex_rs1_data !== 32'hA5A5) $display("FAIL after_wb got %0h want a5a5", ex_rs1_data); else pass_cnt++;
        inst_id = 32'hFFFFFFFF;
        tick();
        total_cnt++; if (ex_illegal !== 1'b1 || ex_ctrl !== 6'h0 || ex_valid !== 1'b1)
            $display("FAIL illegal got ill=%0h ctrl=%0h v=%0h want 1/0/1", ex_illegal, ex_ctrl, ex_valid); else pass_cnt++;
        $display("x0/same-cycle/illegal test done");
    endtask

    task automatic test_random();
        logic [6:0]  opcs [10];
        logic [31:0] mregs [32];
        logic        m_valid;
        logic [5:0]  m_ctrl;
        logic [4:0]  m_rd;
        logic        m_ill, exp_stall, held, bubble;
        dec_t        d, m_dec;
        logic [31:0] m_pc, m_r1, m_r2, inst;
        logic [4:0]  r1, r2;
        int          errs;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
        do_reset();
        for (int k = 0; k < 32; k++) mregs[k] = 0;
        m_valid = 0; m_ctrl = 0; m_rd = 0; held = 0;
        for (int n = 0; n < 500; n++) begin
            if (!held) begin
                inst = $urandom;
                inst[6:0]   = opcs[$urandom_range(0, 9)];
                inst[11:7]  = 5'($urandom_range(0, 3));
                inst[19:15] = 5'($urandom_range(0, 3));
                inst[24:20] = 5'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0: inst[31:25] = 7'h00;
                    1: inst[31:25] = 7'h20;
                    default: ;
                endcase
                if (inst[6:0] inside {7'h67, 7'h03, 7'h23} && $urandom_range(0, 3) != 0) inst[14:12] = 3'd2 & {3{inst[6:0] != 7'h67}};
                inst_id = inst;
                pc_orig_id = $urandom & 32'hFFFFFFFC;
                id_valid = ($urandom_range(0, 9) != 0);
            end
            flush = ($urandom_range(0, 9) == 0);
            wb_en = $urandom_range(0, 1); wb_rd = 5'($urandom_range(0, 4)); wb_data = $urandom;
            #1;
            d = ref_decode(inst_id);
            r1 = inst_id[19:15]; r2 = inst_id[24:20];
            exp_stall = !flush && id_valid && m_valid && m_ctrl[2] && m_rd != 0 &&
                        ((d.u1 && r1 == m_rd) || (d.u2 && r2 == m_rd));
`ifdef WB_BYPASS_EN
            m_r1 = (r1 == 0) ? 0 : (wb_en && wb_rd == r1) ? wb_data : mregs[r1];
            m_r2 = (r2 == 0) ? 0 : (wb_en && wb_rd == r2) ? wb_data : mregs[r2];
`else
            m_r1 = (r1 == 0) ? 0 : mregs[r1];
            m_r2 = (r2 == 0) ? 0 : mregs[r2];
`endif
            total_cnt++; if (stall !== exp_stall) $display("FAIL rnd_stall n=%0d got %0h want %0h", n, stall, exp_stall); else pass_cnt++;
            bubble = flush || !id_valid || exp_stall;
            m_valid = !bubble;
            m_ctrl  = bubble ? 6'h0 : d.ctrl;
            m_rd    = d.rd;
            m_ill   = !bubble && d.ill;
            m_dec   = d;
            m_pc    = pc_orig_id;
            if (wb_en && wb_rd != 0) mregs[wb_rd] = wb_data;
            @(posedge clk);
            #1;
            total_cnt++; if (ex_valid !== m_valid || ex_ctrl !== m_ctrl)
                $display("FAIL rnd_vc n=%0d got v=%0h c=%0h want v=%0h c=%0h", n, ex_valid, ex_ctrl, m_valid, m_ctrl); else pass_cnt++;
            if (m_valid) begin
                errs = 0;
                if (ex_rd !== m_rd || ex_illegal !== m_ill || ex_pc !== m_pc) errs++;
                if (ex_rs1_data !== m_r1 || ex_rs2_data !== m_r2 || ex_funct3 !== inst_id[14:12]) errs++;
                if (!m_dec.ill && (ex_imm !== m_dec.imm || ex_alu_op !== m_dec.op || ex_alu_src !== m_dec.src)) errs++;
                total_cnt++; if (errs != 0)
                    $display("FAIL rnd_fields n=%0d inst=%h got rd=%0h ill=%0h imm=%h op=%0h src=%0h r1=%h r2=%h want rd=%0h ill=%0h imm=%h op=%0h src=%0h r1=%h r2=%h",
                             n, inst_id, ex_rd, ex_illegal, ex_imm, ex_alu_op, ex_alu_src, ex_rs1_data, ex_rs2_data,
                             m_rd, m_ill, m_dec.imm, m_dec.op, m_dec.src, m_r1, m_r2);
                else pass_cnt++;
            end
            held = exp_stall;
        end
        $display("random test done");
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use(1'b0);
        test_load_use(1'b1);
        test_reset_mid_stall();
        test_x0_and_same_cycle();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
